rocc_cmd_queue: RTL and testbench
=================================

Name: rocc_cmd_queue

Overview:
Parametrised successor to the single-entry RoCC command adapter. It sits between the issue stage and a RoCC accelerator and buffers up to CMD_DEPTH commands. It tracks up to MAX_OUTSTANDING in-flight transaction IDs so that in-order responses are re-tagged for writeback. On flush it discards queued commands and silently absorbs the responses of commands already sent to the accelerator.

Parameters:
XLEN, 64, operand and result width
TRANS_ID_BITS, 3, scoreboard transaction-ID width
CMD_DEPTH, 4, command FIFO entries (power of two, >=2)
MAX_OUTSTANDING, 4, maximum of queued + in-flight + pending-drop commands (>= CMD_DEPTH)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
flush_i  in  1  pipeline flush
issue_valid_i  in  1  issue has a RoCC instruction
issue_ready_o  out  1  block can accept it
operand_a_i  in  XLEN  rs1 value
operand_b_i  in  XLEN  rs2 value
instr_i  in  32  raw instruction
trans_id_i  in  TRANS_ID_BITS  scoreboard tag
cmd_valid_o  out  1  command to accelerator valid
cmd_ready_i  in  1  accelerator accepts command
cmd_rs1_o  out  XLEN  command rs1
cmd_rs2_o  out  XLEN  command rs2
cmd_instr_o  out  32  command instruction
resp_valid_i  in  1  accelerator response valid
resp_ready_o  out  1  always 1
resp_data_i  in  XLEN  response data
result_valid_o  out  1  writeback valid (single-cycle pulse)
result_o  out  XLEN  writeback data
trans_id_o  out  TRANS_ID_BITS  writeback tag
busy_o  out  1  any command queued, in flight or pending drop
err_o  out  1  sticky: response arrived with nothing outstanding

Behaviour:
- Reset (rst_i=1 at posedge): both FIFOs empty, drop_cnt=0, err_o=0, result_valid_o=0, result_o=0, trans_id_o=0. Counters are also zero, so cmd_valid_o=0, busy_o=0 and issue_ready_o=1 once rst_i falls.
- Occupancy: occ = cmd_count + tag_count + drop_cnt.
- issue_ready_o = ~flush_i & ~cmd_full & (occ < MAX_OUTSTANDING).
  - Depends only on registered state and flush_i, never on issue_valid_i.
- Accept (issue_valid_i & issue_ready_o): push {operand_a_i, operand_b_i, instr_i, trans_id_i} into the command FIFO.
  - No fall-through: cmd_valid_o rises at the earliest the cycle after acceptance.
- cmd_valid_o = ~cmd_empty & ~flush_i. The cmd_* outputs show the FIFO head and are stable until the handshake.
- Command handshake (cmd_valid_o & cmd_ready_i): pop the command FIFO and push the head trans_id into the tag FIFO, in the same cycle.
- Push and pop in the same cycle on either FIFO: count unchanged. Full and empty are judged on pre-cycle state.
- Response handling, with resp_ready_o=1:
  - resp_valid_i with drop_cnt>0: drop_cnt decrements; no result.
  - resp_valid_i with drop_cnt==0 and tags present: pop the tag head. Next cycle result_valid_o=1, result_o=resp_data_i, trans_id_o=popped tag. Latency is exactly 1 cycle.
  - resp_valid_i with drop_cnt==0 and no tags: response ignored; err_o set, cleared only by rst_i.
- Responses are assumed in command order; the accelerator performs no reordering.
- Flush (flush_i=1):
  - Command FIFO cleared; tag FIFO cleared.
  - drop_cnt_d = drop_cnt + tag_count − (resp_valid_i ? 1 : 0). Any response in the flush cycle is never written back.
  - result_valid_o is 0 in the cycle after a flush.
  - No command handshake and no issue accept can occur during flush.
- drop_cnt width is $clog2(MAX_OUTSTANDING+1); it is bounded because occ ≤ MAX_OUTSTANDING.
- busy_o = (occ != 0).
- No FSM beyond the counters; all pointers wrap modulo the depth.

Optional Feature:
ROCC_PERF_CNT_EN
- Defined: adds 32-bit outputs perf_cmd_cnt_o (counts command handshakes) and perf_stall_cnt_o (counts cycles with issue_valid_i & ~issue_ready_o). Both saturate at all-ones and clear on rst_i only, not on flush.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- rocc_pkg:
  - rocc_cmd_t struct {rs1, rs2, instr, trans_id}
  - TRANS_ID_BITS default
  - RoCC opcode constants
- One sub-module: rocc_fifo, a generic synchronous FIFO parametrised by type/width and depth, with push/pop/full/empty/count and a flush clear.
  - Instantiated twice: the command FIFO (rocc_cmd_t) and the tag FIFO (TRANS_ID_BITS, MAX_OUTSTANDING deep).

Test Plan:
- Back-to-back issue of 4 commands (ids 1..4), cmd_ready_i=0 → all accepted. Fifth stalls (issue_ready_o=0); cmd_valid_o=1 showing id 1's operands, stable.
- cmd_ready_i=1, responses 0xA,0xB,0xC,0xD one per cycle → result_valid_o pulses 1 cycle after each response, with tags 1,2,3,4 and data 0xA..0xD.
- 2 commands sent to accelerator, 2 queued, then flush_i → queue empties, drop_cnt=2. Next two responses produce no result_valid_o; the third command after the flush (id 5) returns with tag 5.
- flush_i in the same cycle as a response with 3 tags outstanding → that response is not written back; drop_cnt=2; busy_o stays 1 until 2 more responses arrive.
- resp_valid_i with nothing outstanding → no result; err_o=1 and stays 1 until rst_i.
- rst_i asserted mid-traffic (2 queued, 1 in flight) → next cycle all outputs at reset values; issue_ready_o=1 once rst_i falls.

Source files
------------

// File: rtl/rocc_pkg.sv
// Shared types and constants for the RoCC command queue.
// Optional perf counters are enabled with ROCC_PERF_CNT_EN.
package rocc_pkg;

    localparam int unsigned ROCC_XLEN          = 64;
    localparam int unsigned ROCC_TRANS_ID_BITS = 3;

    localparam logic [6:0] ROCC_OPC_CUSTOM0 = 7'b0001011;
    localparam logic [6:0] ROCC_OPC_CUSTOM1 = 7'b0101011;
    localparam logic [6:0] ROCC_OPC_CUSTOM2 = 7'b1011011;
    localparam logic [6:0] ROCC_OPC_CUSTOM3 = 7'b1111011;

    typedef struct packed {
        logic [ROCC_XLEN-1:0]          rs1;
        logic [ROCC_XLEN-1:0]          rs2;
        logic [31:0]                   instr;
        logic [ROCC_TRANS_ID_BITS-1:0] trans_id;
    } rocc_cmd_t;

    function automatic logic is_rocc_opcode(input logic [6:0] opc);
        return (opc == ROCC_OPC_CUSTOM0) || (opc == ROCC_OPC_CUSTOM1) ||
               (opc == ROCC_OPC_CUSTOM2) || (opc == ROCC_OPC_CUSTOM3);
    endfunction

endpackage

// File: rtl/rocc_fifo.sv
// Generic synchronous FIFO with flush clear; pointers wrap modulo DEPTH.
// Full/empty reflect pre-cycle state; simultaneous push/pop keeps count.
module rocc_fifo #(
    parameter type         T     = logic [7:0],
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  T              data_i,
    input  logic          pop_i,
    output T              data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    T              mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt == CW'(DEPTH));
    assign empty_o = (cnt == '0);
    assign count_o = cnt;
    assign data_o  = mem[rptr];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= nxt(wptr);
            if (do_pop)  rptr <= nxt(rptr);
            if (do_push && !do_pop)
                cnt <= cnt + 1'b1;
            else if (!do_push && do_pop)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= data_i;
    end

endmodule

// File: rtl/rocc_cmd_queue.sv
// Buffered RoCC command adapter with in-order response re-tagging.
// Define ROCC_PERF_CNT_EN to add saturating perf counter outputs.
module rocc_cmd_queue
    import rocc_pkg::*;
#(
    parameter int unsigned XLEN            = ROCC_XLEN,
    parameter int unsigned TRANS_ID_BITS   = ROCC_TRANS_ID_BITS,
    parameter int unsigned CMD_DEPTH       = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [XLEN-1:0]          operand_b_i,
    input  logic [31:0]              instr_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    output logic [XLEN-1:0]          cmd_rs1_o,
    output logic [XLEN-1:0]          cmd_rs2_o,
    output logic [31:0]              cmd_instr_o,
    input  logic                     resp_valid_i,
    output logic                     resp_ready_o,
    input  logic [XLEN-1:0]          resp_data_i,
    output logic                     result_valid_o,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic                     busy_o,
`ifdef ROCC_PERF_CNT_EN
    output logic [31:0]              perf_cmd_cnt_o,
    output logic [31:0]              perf_stall_cnt_o,
`endif
    output logic                     err_o
);

    localparam int unsigned CCW = $clog2(CMD_DEPTH + 1);
    localparam int unsigned TCW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned DW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned OW  = DW + 2;

    // Widths follow the module parameters, unlike the fixed package struct.
    typedef struct packed {
        logic [XLEN-1:0]          rs1;
        logic [XLEN-1:0]          rs2;
        logic [31:0]              instr;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } cmd_t;

    cmd_t                     cmd_in;
    cmd_t                     cmd_head;
    logic                     cmd_full;
    logic                     cmd_empty;
    logic [CCW-1:0]           cmd_count;
    logic [TRANS_ID_BITS-1:0] tag_head;
    logic                     tag_full;
    logic                     tag_empty;
    logic [TCW-1:0]           tag_count;
    logic [DW-1:0]            drop_cnt;
    logic [OW-1:0]            occ;
    logic [OW-1:0]            drop_sum;
    logic                     accept;
    logic                     cmd_fire;
    logic                     resp_drop;
    logic                     resp_wb;
    logic                     resp_orphan;

    assign occ = OW'(cmd_count) + OW'(tag_count) + OW'(drop_cnt);
    assign drop_sum = OW'(drop_cnt) + OW'(tag_count);

    assign issue_ready_o = ~flush_i & ~cmd_full & ~tag_full &
                           (occ < OW'(MAX_OUTSTANDING));
    assign accept        = issue_valid_i & issue_ready_o;
    assign cmd_valid_o   = ~cmd_empty & ~flush_i;
    assign cmd_fire      = cmd_valid_o & cmd_ready_i;
    assign resp_ready_o  = 1'b1;
    assign busy_o        = (occ != '0);

    assign cmd_in.rs1      = operand_a_i;
    assign cmd_in.rs2      = operand_b_i;
    assign cmd_in.instr    = instr_i;
    assign cmd_in.trans_id = trans_id_i;

    assign cmd_rs1_o   = cmd_head.rs1;
    assign cmd_rs2_o   = cmd_head.rs2;
    assign cmd_instr_o = cmd_head.instr;

    assign resp_drop   = resp_valid_i & (drop_cnt != '0);
    assign resp_wb     = resp_valid_i & (drop_cnt == '0) &
                         ~tag_empty & ~flush_i;
    assign resp_orphan = resp_valid_i & (drop_cnt == '0) & tag_empty;

    rocc_fifo #(
        .T     (cmd_t),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (accept),
        .data_i  (cmd_in),
        .pop_i   (cmd_fire),
        .data_o  (cmd_head),
        .full_o  (cmd_full),
        .empty_o (cmd_empty),
        .count_o (cmd_count)
    );

    rocc_fifo #(
        .T     (logic [TRANS_ID_BITS-1:0]),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (cmd_fire),
        .data_i  (cmd_head.trans_id),
        .pop_i   (resp_wb),
        .data_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (tag_count)
    );

    // In-flight tags become pending drops; a response in this cycle retires one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt <= '0;
        end else if (flush_i) begin
            if (resp_valid_i && drop_sum != '0)
                drop_cnt <= DW'(drop_sum - 1'b1);
            else
                drop_cnt <= DW'(drop_sum);
        end else if (resp_drop) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_valid_o <= 1'b0;
            result_o       <= '0;
            trans_id_o     <= '0;
            err_o          <= 1'b0;
        end else begin
            result_valid_o <= resp_wb;
            if (resp_wb) begin
                result_o   <= resp_data_i;
                trans_id_o <= tag_head;
            end
            if (resp_orphan) err_o <= 1'b1;
        end
    end

`ifdef ROCC_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_cmd_cnt_o   <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (cmd_fire && perf_cmd_cnt_o != '1)
                perf_cmd_cnt_o <= perf_cmd_cnt_o + 1'b1;
            if (issue_valid_i && !issue_ready_o && perf_stall_cnt_o != '1)
                perf_stall_cnt_o <= perf_stall_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rocc_cmd_queue.sv
// Directed self-checking bench for rocc_cmd_queue.
// Default build only (perf counter ports absent).
module tb_rocc_cmd_queue;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [63:0] operand_a_i;
    logic [63:0] operand_b_i;
    logic [31:0] instr_i;
    logic [2:0]  trans_id_i;
    logic        cmd_valid_o;
    logic        cmd_ready_i;
    logic [63:0] cmd_rs1_o;
    logic [63:0] cmd_rs2_o;
    logic [31:0] cmd_instr_o;
    logic        resp_valid_i;
    logic        resp_ready_o;
    logic [63:0] resp_data_i;
    logic        result_valid_o;
    logic [63:0] result_o;
    logic [2:0]  trans_id_o;
    logic        busy_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rocc_cmd_queue dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .operand_a_i    (operand_a_i),
        .operand_b_i    (operand_b_i),
        .instr_i        (instr_i),
        .trans_id_i     (trans_id_i),
        .cmd_valid_o    (cmd_valid_o),
        .cmd_ready_i    (cmd_ready_i),
        .cmd_rs1_o      (cmd_rs1_o),
        .cmd_rs2_o      (cmd_rs2_o),
        .cmd_instr_o    (cmd_instr_o),
        .resp_valid_i   (resp_valid_i),
        .resp_ready_o   (resp_ready_o),
        .resp_data_i    (resp_data_i),
        .result_valid_o (result_valid_o),
        .result_o       (result_o),
        .trans_id_o     (trans_id_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input int k);
        issue_valid_i = 1'b1;
        operand_a_i   = 64'hA000 + 64'(k);
        operand_b_i   = 64'hB000 + 64'(k);
        instr_i       = 32'h0000_000B | (32'(k) << 12);
        trans_id_i    = 3'(k);
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; issue_valid_i = 1'b0;
        operand_a_i = '0; operand_b_i = '0; instr_i = '0; trans_id_i = '0;
        cmd_ready_i = 1'b0; resp_valid_i = 1'b0; resp_data_i = '0;

        // reset state
        step(); step();
        chk("rst_result_valid", 64'(result_valid_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_trans_id", 64'(trans_id_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_resp_ready", 64'(resp_ready_o), 64'd1);
        rst_i = 1'b0;
        #1;
        chk("rst_issue_ready", 64'(issue_ready_o), 64'd1);
        chk("rst_cmd_valid", 64'(cmd_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);

        // fill queue, fifth stalls
        for (int k = 1; k <= 4; k++) begin
            set_issue(k);
            #1;
            chk("fill_issue_ready", 64'(issue_ready_o), 64'd1);
            if (k == 1) chk("no_fallthrough", 64'(cmd_valid_o), 64'd0);
            step();
        end
        set_issue(5);
        #1;
        chk("fifth_stall", 64'(issue_ready_o), 64'd0);
        chk("head_valid", 64'(cmd_valid_o), 64'd1);
        chk("head_rs1", cmd_rs1_o, 64'hA001);
        step();
        chk("head_rs1_stable", cmd_rs1_o, 64'hA001);
        chk("head_rs2_stable", cmd_rs2_o, 64'hB001);
        chk("head_instr_stable", 64'(cmd_instr_o), 64'h100B);
        chk("still_stall", 64'(issue_ready_o), 64'd0);
        issue_valid_i = 1'b0;

        // send all four, then return responses in order
        cmd_ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("send_rs1", cmd_rs1_o, 64'hA000 + 64'(k));
            step();
        end
        cmd_ready_i = 1'b0;
        #1;
        chk("sent_cmd_valid", 64'(cmd_valid_o), 64'd0);
        chk("inflight_full", 64'(issue_ready_o), 64'd0);
        chk("inflight_busy", 64'(busy_o), 64'd1);
        for (int j = 0; j < 4; j++) begin
            resp_valid_i = 1'b1;
            resp_data_i  = 64'hA + 64'(j);
            #1;
            if (j == 0) begin
                chk("resp_no_early", 64'(result_valid_o), 64'd0);
            end else begin
                chk("resp_valid", 64'(result_valid_o), 64'd1);
                chk("resp_data", result_o, 64'hA + 64'(j - 1));
                chk("resp_tag", 64'(trans_id_o), 64'(j));
            end
            step();
        end
        resp_valid_i = 1'b0;
        #1;
        chk("resp_valid_last", 64'(result_valid_o), 64'd1);
        chk("resp_data_last", result_o, 64'hD);
        chk("resp_tag_last", 64'(trans_id_o), 64'd4);
        step();
        chk("resp_pulse_end", 64'(result_valid_o), 64'd0);
        chk("drained_busy", 64'(busy_o), 64'd0);

        // flush with 2 in flight and 2 queued
        for (int k = 1; k <= 4; k++) begin
            set_issue(k);
            step();
        end
        issue_valid_i = 1'b0;
        cmd_ready_i   = 1'b1;
        step(); step();
        cmd_ready_i = 1'b0;
        flush_i     = 1'b1;
        #1;
        chk("flush_issue_ready", 64'(issue_ready_o), 64'd0);
        chk("flush_cmd_valid", 64'(cmd_valid_o), 64'd0);
        step();
        flush_i = 1'b0;
        #1;
        chk("post_flush_cmd_valid", 64'(cmd_valid_o), 64'd0);
        chk("post_flush_busy", 64'(busy_o), 64'd1);
        chk("post_flush_result", 64'(result_valid_o), 64'd0);
        chk("post_flush_ready", 64'(issue_ready_o), 64'd1);
        set_issue(5);
        resp_valid_i = 1'b1;
        resp_data_i  = 64'h11;
        step();
        issue_valid_i = 1'b0;
        cmd_ready_i   = 1'b1;
        resp_data_i   = 64'h22;
        #1;
        chk("drop1_no_result", 64'(result_valid_o), 64'd0);
        chk("id5_head", cmd_rs1_o, 64'hA005);
        step();
        cmd_ready_i = 1'b0;
        resp_data_i = 64'h55;
        #1;
        chk("drop2_no_result", 64'(result_valid_o), 64'd0);
        step();
        resp_valid_i = 1'b0;
        #1;
        chk("id5_valid", 64'(result_valid_o), 64'd1);
        chk("id5_data", result_o, 64'h55);
        chk("id5_tag", 64'(trans_id_o), 64'd5);
        step();
        chk("id5_idle", 64'(busy_o), 64'd0);

        // flush coinciding with a response, 3 tags outstanding
        cmd_ready_i = 1'b1;
        set_issue(1); step();
        set_issue(2); step();
        set_issue(3); step();
        issue_valid_i = 1'b0;
        step();
        cmd_ready_i  = 1'b0;
        flush_i      = 1'b1;
        resp_valid_i = 1'b1;
        resp_data_i  = 64'h77;
        step();
        flush_i     = 1'b0;
        resp_data_i = 64'h88;
        #1;
        chk("fr_no_result", 64'(result_valid_o), 64'd0);
        chk("fr_busy1", 64'(busy_o), 64'd1);
        step();
        resp_data_i = 64'h99;
        #1;
        chk("fr_drop_a", 64'(result_valid_o), 64'd0);
        chk("fr_busy2", 64'(busy_o), 64'd1);
        step();
        resp_valid_i = 1'b0;
        #1;
        chk("fr_drop_b", 64'(result_valid_o), 64'd0);
        chk("fr_idle", 64'(busy_o), 64'd0);
        chk("fr_err", 64'(err_o), 64'd0);
        chk("fr_result_hold", result_o, 64'h55);

        // orphan response
        resp_valid_i = 1'b1;
        resp_data_i  = 64'hEE;
        step();
        resp_valid_i = 1'b0;
        #1;
        chk("orphan_no_result", 64'(result_valid_o), 64'd0);
        chk("orphan_err", 64'(err_o), 64'd1);
        step();
        chk("orphan_err_sticky", 64'(err_o), 64'd1);

        // reset mid-traffic
        set_issue(1); step();
        set_issue(2);
        cmd_ready_i = 1'b1;
        step();
        set_issue(3);
        cmd_ready_i = 1'b0;
        step();
        issue_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("pre_rst_busy", 64'(busy_o), 64'd1);
        step();
        chk("mid_rst_result_valid", 64'(result_valid_o), 64'd0);
        chk("mid_rst_result", result_o, 64'd0);
        chk("mid_rst_trans_id", 64'(trans_id_o), 64'd0);
        chk("mid_rst_err", 64'(err_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_cmd_valid", 64'(cmd_valid_o), 64'd0);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_issue_ready", 64'(issue_ready_o), 64'd1);
        step();
        chk("mid_rst_idle", 64'(busy_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
